hada_divmod: RTL and testbench
==============================

HADA_DIVMOD -- requirements
Module: hada_divmod

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter SIGNED, default 1: 1 gives Int semantics, 0 gives Word semantics.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand pair is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-007 The block SHALL have port in_a, input, WIDTH bits: dividend.
REQ-008 The block SHALL have port in_b, input, WIDTH bits: divisor.
REQ-009 The block SHALL have port in_floor, input, 1 bit: 0 selects quotRem, 1 selects divMod.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_q, output, WIDTH bits: quotient.
REQ-013 The block SHALL have port out_r, output, WIDTH bits: remainder or modulus.
REQ-014 The block SHALL have port out_div0, output, 1 bit: the divisor was zero.
REQ-015 The block SHALL have port out_ovf, output, 1 bit: signed overflow (minBound divided by -1).

Function
REQ-016 The block SHALL use FSM states IDLE, CALC, FIXUP and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; an accept is in_valid and in_ready sampled high on the same edge.
REQ-018 On accept, the block SHALL register the operands and in_floor, and capture absolute values when SIGNED=1 (sign-extended to WIDTH+1 so that minBound is handled).
REQ-019 On accept with in_b==0, the block SHALL go to DONE with out_q=0, out_r=in_a, out_div0=1 and out_ovf=0; CALC SHALL be skipped.
REQ-020 On accept with SIGNED=1, in_a==minBound and in_b==-1, the block SHALL go to DONE with out_q=minBound, out_r=0 and out_ovf=1.
REQ-021 Otherwise, IDLE SHALL go to CALC.
REQ-022 CALC SHALL run a restoring radix-2 shift-subtract for exactly WIDTH cycles, driven by an iteration counter that runs from WIDTH-1 down to 0.
REQ-023 CALC SHALL go to FIXUP when the counter reaches 0.
REQ-024 FIXUP SHALL take one cycle to apply signs for quotRem: quotient negative iff the operand signs differ (truncate toward zero); remainder takes the sign of the dividend.
REQ-025 When in_floor=1, the nonzero remainder has a sign different from the divisor's, and SIGNED=1, FIXUP SHALL additionally set q=q-1 and r=r+b; mod then takes the sign of the divisor.
REQ-026 FIXUP SHALL then go to DONE.
REQ-027 With SIGNED=0, in_floor SHALL have no effect and the block SHALL perform no sign handling.
REQ-028 Latency SHALL be fixed: for normal operands out_valid rises WIDTH+2 cycles after the accept edge; for div0/ovf operands it rises 1 cycle after.
REQ-029 In DONE, out_valid SHALL be 1 and all out_* SHALL be held stable until out_ready=1.
REQ-030 When out_ready=1 in DONE, the block SHALL go to IDLE on the next edge; out_valid SHALL not go high again without a new accept.
REQ-031 There SHALL be no pipelining: at most one operation is in flight, and in_valid is ignored outside IDLE.
REQ-032 out_q and out_r SHALL be WIDTH-bit two's-complement (or unsigned) results, and every identity a == q*b + r SHALL hold modulo 2^WIDTH for non-div0 cases.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter.
REQ-034 While rst=1 at a clock edge, the block SHALL set in_ready=0 during reset, and to 1 on the first edge after release.
REQ-035 While rst=1 at a clock edge, the block SHALL set out_valid=0, out_q=0, out_r=0, out_div0=0 and out_ovf=0.
REQ-036 Reset asserted mid-CALC, mid-FIXUP or in DONE SHALL abort the operation; no result SHALL be emitted afterward.

Verification
REQ-037 The bench SHALL cover: WIDTH=8, SIGNED=1, a=-7, b=2, floor=0 -> q=-3 (0xFD), r=-1 (0xFF), out_valid exactly 10 cycles after accept.
REQ-038 The bench SHALL cover: same operands with floor=1 -> q=-4 (0xFC), r=1; also a=7, b=-2, floor=1 -> q=-4, r=-1.
REQ-039 The bench SHALL cover: a=7, b=0 -> out_div0=1, q=0, r=7, out_valid 1 cycle after accept.
REQ-040 The bench SHALL cover: a=-128, b=-1 -> out_ovf=1, q=0x80, r=0; also SIGNED=0, a=0xF9, b=2 -> q=0x7C, r=1.
REQ-041 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; one cycle after out_ready=1 -> in_ready=1.
REQ-042 The bench SHALL cover: rst pulsed on the 4th CALC cycle -> out_valid stays 0, outputs 0, in_ready=1 after release, and the next operation computes correctly.
REQ-043 The bench SHALL cover random signed/unsigned operands for WIDTH=8 and 64 against a Haskell quotRem/divMod reference model.

Source files
------------

// File: rtl/hada_divmod.sv
// Sequential integer divider: restoring radix-2 shift-subtract with Haskell quotRem/divMod
// semantics, one operation in flight, valid/ready handshakes on both sides.
module hada_divmod #(
    parameter int WIDTH  = 64,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_floor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_div0,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_BOUND = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Operation context captured on accept
    logic                    neg_a;
    logic                    neg_b;
    logic                    floor_reg;
    logic signed [WIDTH-1:0] b_reg;
    logic [WIDTH:0]          abs_b;

    // quo starts as |a| and shifts left; quotient bits enter at the bottom as dividend bits leave the top
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   trial;

    logic                    accept;
    logic                    is_div0;
    logic                    is_ovf;
    logic signed [WIDTH-1:0] q_trunc;
    logic signed [WIDTH-1:0] r_trunc;
    logic signed [WIDTH-1:0] fix_q;
    logic signed [WIDTH-1:0] fix_r;
    logic                    floor_fix;

    function automatic logic is_neg(input logic [WIDTH-1:0] v);
        return (SIGNED != 0) && v[WIDTH-1];
    endfunction

    // One extra bit keeps the negation of minBound exact
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {is_neg(v), v};
        return is_neg(v) ? -ext : ext;
    endfunction

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                           input logic neg);
        return neg ? -mag : mag;
    endfunction

    assign accept  = (state == IDLE) && in_ready && in_valid;
    assign is_div0 = (in_b == '0);
    assign is_ovf  = (SIGNED != 0) && (in_a == MIN_BOUND) && (in_b == ALL_ONES);
    assign trial   = {rem, quo[WIDTH-1]};

    // Sign restoration (truncating), then the floor correction when mod must follow the divisor
    always_comb begin
        q_trunc   = apply_sign(quo, neg_a ^ neg_b);
        r_trunc   = apply_sign(rem, neg_a);
        floor_fix = (SIGNED != 0) && floor_reg && (rem != '0) && (neg_a != neg_b);
        fix_q     = q_trunc;
        fix_r     = r_trunc;
        if (floor_fix) begin
            fix_q = q_trunc - WIDTH'(1);
            fix_r = r_trunc + b_reg;
        end
    end

    // Datapath: operand capture, then one restoring step per CALC cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            neg_a     <= is_neg(in_a);
            neg_b     <= is_neg(in_b);
            floor_reg <= in_floor;
            b_reg     <= in_b;
            abs_b     <= magnitude(in_b);
            quo       <= WIDTH'(magnitude(in_a));
            rem       <= '0;
        end else if (state == CALC) begin
            if (trial >= abs_b) begin
                rem <= WIDTH'(trial - abs_b);
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_div0  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (is_div0) begin
                            out_q     <= '0;
                            out_r     <= in_a;
                            out_div0  <= 1'b1;
                            out_ovf   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (is_ovf) begin
                            out_q     <= MIN_BOUND;
                            out_r     <= '0;
                            out_div0  <= 1'b0;
                            out_ovf   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt   <= CNT_W'(WIDTH - 1);
                            state <= CALC;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        state <= FIXUP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIXUP: begin
                    out_q     <= fix_q;
                    out_r     <= fix_r;
                    out_div0  <= 1'b0;
                    out_ovf   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hada_divmod.sv
// Scoreboard bench for hada_divmod: four instances (8/64 bit, signed/unsigned), directed
// vectors with hand-computed results plus random operands checked against a quotRem/divMod model.
module tb_hada_divmod;

    typedef struct {
        int          inst;
        int          tag;
        logic [63:0] q;
        logic [63:0] r;
        logic        d0;
        logic        ov;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_floor;
    logic        out_ready;
    logic [3:0]  ivld;
    logic [3:0]  irdy;
    logic [3:0]  ovld;
    logic [3:0]  odiv0;
    logic [3:0]  oovf;
    logic [7:0]  q_0, r_0, q_1, r_1;
    logic [63:0] q_2, r_2, q_3, r_3;
    logic [63:0] oq [4];
    logic [63:0] orr [4];

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_push = 0;
    int          n_pop = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [3:0]  ov_prev = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hada_divmod #(.WIDTH(8), .SIGNED(1)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(ivld[0]), .in_ready(irdy[0]),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_floor(in_floor),
        .out_valid(ovld[0]), .out_ready(out_ready), .out_q(q_0), .out_r(r_0),
        .out_div0(odiv0[0]), .out_ovf(oovf[0]));

    hada_divmod #(.WIDTH(8), .SIGNED(0)) u_u8 (
        .clk(clk), .rst(rst), .in_valid(ivld[1]), .in_ready(irdy[1]),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_floor(in_floor),
        .out_valid(ovld[1]), .out_ready(out_ready), .out_q(q_1), .out_r(r_1),
        .out_div0(odiv0[1]), .out_ovf(oovf[1]));

    hada_divmod #(.WIDTH(64), .SIGNED(1)) u_s64 (
        .clk(clk), .rst(rst), .in_valid(ivld[2]), .in_ready(irdy[2]),
        .in_a(in_a), .in_b(in_b), .in_floor(in_floor),
        .out_valid(ovld[2]), .out_ready(out_ready), .out_q(q_2), .out_r(r_2),
        .out_div0(odiv0[2]), .out_ovf(oovf[2]));

    hada_divmod #(.WIDTH(64), .SIGNED(0)) u_u64 (
        .clk(clk), .rst(rst), .in_valid(ivld[3]), .in_ready(irdy[3]),
        .in_a(in_a), .in_b(in_b), .in_floor(in_floor),
        .out_valid(ovld[3]), .out_ready(out_ready), .out_q(q_3), .out_r(r_3),
        .out_div0(odiv0[3]), .out_ovf(oovf[3]));

    always_comb begin
        oq[0]  = {56'd0, q_0};
        orr[0] = {56'd0, r_0};
        oq[1]  = {56'd0, q_1};
        orr[1] = {56'd0, r_1};
        oq[2]  = q_2;
        orr[2] = r_2;
        oq[3]  = q_3;
        orr[3] = r_3;
    end

    task automatic chk(input string what, input int tag, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", what, tag, act, req);
        end
    endtask

    // Haskell quotRem / divMod reference for w-bit Int (sgn=1) or Word (sgn=0)
    function automatic void model(input int w, input bit sgn, input logic [63:0] a,
                                  input logic [63:0] b, input bit fl,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic d0, output logic ov);
        logic [63:0] mask, am, bm;
        longint      sa, sb, qq, rr, minb;
        mask = (64'(1) << w) - 64'(1);
        if (w == 64) mask = '1;
        am = a & mask;
        bm = b & mask;
        d0 = 1'b0;
        ov = 1'b0;
        if (bm == 64'd0) begin
            q  = 64'd0;
            r  = am;
            d0 = 1'b1;
        end else if (sgn) begin
            sa   = longint'(am << (64 - w));
            sa   = sa >>> (64 - w);
            sb   = longint'(bm << (64 - w));
            sb   = sb >>> (64 - w);
            minb = -(longint'(64'(1) << (w - 1)));
            if (sa == minb && sb == -1) begin
                q  = 64'(minb) & mask;
                r  = 64'd0;
                ov = 1'b1;
            end else begin
                qq = sa / sb;
                rr = sa % sb;
                if (fl && rr != 0 && ((rr < 0) != (sb < 0))) begin
                    qq = qq - 1;
                    rr = rr + sb;
                end
                q = 64'(qq) & mask;
                r = 64'(rr) & mask;
            end
        end else begin
            q = am / bm;
            r = am % bm;
        end
    endfunction

    // Called on a negedge; returns on the negedge following the accept edge
    task automatic issue(input int inst, input int tag, input logic [63:0] a,
                         input logic [63:0] b, input logic fl, input bit push,
                         input logic [63:0] eq, input logic [63:0] er,
                         input logic ed0, input logic eov, input int lat);
        int   t;
        exp_t e;
        t = 0;
        while (irdy[inst] !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout (vec %0d): got in_ready=0, expected 1", tag);
        end
        if (push) begin
            e.inst = inst; e.tag = tag; e.q = eq; e.r = er;
            e.d0 = ed0; e.ov = eov; e.lat = lat;
            sbq.push_back(e);
            n_push++;
        end
        in_a        = a;
        in_b        = b;
        in_floor    = fl;
        ivld[inst]  = 1'b1;
        acc_cyc     = cyc + 1;
        @(negedge clk);
        ivld[inst]  = 1'b0;
    endtask

    task automatic wait_done(input int tag);
        int t;
        t = 0;
        while (n_pop < n_push && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (n_pop < n_push) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_valid_timeout (vec %0d): got no result, expected one", tag);
            n_pop = n_push;
            sbq.delete();
        end
    endtask

    task automatic dv(input int inst, input int tag, input logic [63:0] a,
                      input logic [63:0] b, input logic fl, input logic [63:0] eq,
                      input logic [63:0] er, input logic ed0, input logic eov,
                      input int lat);
        issue(inst, tag, a, b, fl, 1'b1, eq, er, ed0, eov, lat);
        wait_done(tag);
    endtask

    // Monitor: each rising out_valid must match the oldest expected result
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ovld[i] === 1'b1 && ov_prev[i] == 1'b0) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out (inst %0d): got out_valid=1, expected 0", i);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("instance", mon_e.tag, 64'(i), 64'(mon_e.inst));
                    chk("out_q", mon_e.tag, oq[i], mon_e.q);
                    chk("out_r", mon_e.tag, orr[i], mon_e.r);
                    chk("out_div0", mon_e.tag, 64'(odiv0[i]), 64'(mon_e.d0));
                    chk("out_ovf", mon_e.tag, 64'(oovf[i]), 64'(mon_e.ov));
                    chk("latency", mon_e.tag, 64'(cyc + 1 - acc_cyc), 64'(mon_e.lat));
                    n_pop++;
                end
            end
            ov_prev[i] = (ovld[i] === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        bit          sgn;
        bit          fl;
        logic [63:0] a, b, eq, er;
        logic        ed0, eov;
        bit          stuck;

        rst       = 1'b1;
        ivld      = '0;
        in_a      = '0;
        in_b      = '0;
        in_floor  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", 0, 64'(irdy), 64'h0);
        chk("rst_out_valid", 0, 64'(ovld), 64'h0);
        chk("rst_flags", 0, 64'({odiv0, oovf}), 64'h0);
        chk("rst_q_r_8", 0, oq[0] | orr[0] | oq[1] | orr[1], 64'h0);
        chk("rst_q_r_64", 0, oq[2] | orr[2] | oq[3] | orr[3], 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 0, 64'(irdy), 64'hF);

        // 8-bit Int
        dv(0, 1, 64'hF9, 64'h02, 1'b0, 64'hFD, 64'hFF, 1'b0, 1'b0, 10);
        dv(0, 2, 64'hF9, 64'h02, 1'b1, 64'hFC, 64'h01, 1'b0, 1'b0, 10);
        dv(0, 3, 64'h07, 64'hFE, 1'b1, 64'hFC, 64'hFF, 1'b0, 1'b0, 10);
        dv(0, 4, 64'h07, 64'h00, 1'b0, 64'h00, 64'h07, 1'b1, 1'b0, 1);
        dv(0, 5, 64'h80, 64'hFF, 1'b0, 64'h80, 64'h00, 1'b0, 1'b1, 1);
        dv(0, 6, 64'h80, 64'h01, 1'b0, 64'h80, 64'h00, 1'b0, 1'b0, 10);
        dv(0, 7, 64'h80, 64'h80, 1'b1, 64'h01, 64'h00, 1'b0, 1'b0, 10);
        dv(0, 8, 64'h05, 64'h80, 1'b1, 64'hFF, 64'h85, 1'b0, 1'b0, 10);
        dv(0, 9, 64'h81, 64'h7F, 1'b1, 64'hFF, 64'h00, 1'b0, 1'b0, 10);
        // 8-bit Word: floor ignored, no overflow case
        dv(1, 10, 64'hF9, 64'h02, 1'b0, 64'h7C, 64'h01, 1'b0, 1'b0, 10);
        dv(1, 11, 64'hF9, 64'h02, 1'b1, 64'h7C, 64'h01, 1'b0, 1'b0, 10);
        dv(1, 12, 64'h80, 64'hFF, 1'b0, 64'h00, 64'h80, 1'b0, 1'b0, 10);
        // 64-bit Int and Word
        dv(2, 13, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1,
           1'b0, 1'b0, 66);
        dv(2, 14, 64'h8000_0000_0000_0000, '1, 1'b0, 64'h8000_0000_0000_0000, 64'h0,
           1'b0, 1'b1, 1);
        dv(3, 15, '1, 64'h3, 1'b0, 64'h5555_5555_5555_5555, 64'h0, 1'b0, 1'b0, 66);
        dv(3, 16, 64'h5, 64'h0, 1'b0, 64'h0, 64'h5, 1'b1, 1'b0, 1);

        // Back-pressure: result held while out_ready is low
        out_ready = 1'b0;
        issue(0, 20, 64'd100, 64'd7, 1'b0, 1'b1, 64'h0E, 64'h02, 1'b0, 1'b0, 10);
        wait_done(20);
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 20, 64'(ovld[0]), 64'h1);
            chk("hold_q", 20, oq[0], 64'h0E);
            chk("hold_r", 20, orr[0], 64'h02);
            chk("hold_in_ready", 20, 64'(irdy[0]), 64'h0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 20, 64'(ovld[0]), 64'h0);
        chk("release_in_ready", 20, 64'(irdy[0]), 64'h1);

        // Reset during the 4th CALC cycle aborts the operation
        issue(0, 30, 64'h55, 64'h03, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 30, 64'(ovld[0]), 64'h0);
        chk("abort_in_ready", 30, 64'(irdy[0]), 64'h0);
        chk("abort_q_r", 30, oq[0] | orr[0], 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 30, 64'(irdy[0]), 64'h1);
        stuck = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (ovld[0] !== 1'b0) stuck = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_result", 30, 64'(stuck), 64'h0);
        dv(0, 31, 64'd100, 64'd7, 1'b0, 64'h0E, 64'h02, 1'b0, 1'b0, 10);

        // Random operands against the reference model
        for (int inst = 0; inst < 4; inst++) begin
            for (int k = 0; k < 25; k++) begin
                w   = (inst < 2) ? 8 : 64;
                sgn = (inst % 2 == 0);
                a   = {$urandom, $urandom};
                b   = {$urandom, $urandom} >> $urandom_range(0, 62);
                case ($urandom_range(0, 9))
                    0: b = 64'd0;
                    1: b = '1;
                    2: begin a = 64'(1) << (w - 1); b = '1; end
                    3: b = 64'($urandom_range(1, 5));
                    4: a = 64'(1) << (w - 1);
                    default: ;
                endcase
                fl = 1'($urandom_range(0, 1));
                model(w, sgn, a, b, fl, eq, er, ed0, eov);
                dv(inst, 100 + inst * 100 + k, a, b, fl, eq, er, ed0, eov,
                   (ed0 || eov) ? 1 : w + 2);
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
